bit_serializer: RTL

//  Parallel-to-serial front end for the serial pattern detector. Accepts WIDTH-bit words on a

---
 rtl/ser_pkg.sv | 19 +
 rtl/bit_tick_gen.sv | 41 ++++
 rtl/bit_serializer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the bit serializer: FSM encodings, default idle level
// and a counter-width helper.
package ser_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic DEF_IDLE_BIT = 1'b1;

    // Bits needed to count 0..n-1; never less than 1 so single-value counters stay legal.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-time divider: down-counter marking the first and last clk cycle of each bit-time.
// load_i restarts a bit-time; the count runs only while en_i is high.
module bit_tick_gen
    import ser_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic load_i,
    output logic tick_first_o,
    output logic tick_last_o
);

    localparam int               DIV_W   = clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;

    assign tick_first_o = (div_q == DIV_TOP);
    assign tick_last_o  = (div_q == '0);

    always_comb begin
        div_d = div_q;
        if (load_i) begin
            div_d = DIV_TOP;
        end else if (en_i) begin
            div_d = tick_last_o ? DIV_TOP : div_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end with a one-word holding register.
//   state   | meaning
//   S_IDLE  | line at IDLE_BIT, waiting for a held word
//   S_SHIFT | shifting the current word out, one bit per bit-time
//   S_GAP   | inter-word idle bit-times
module bit_serializer
    import ser_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter int   CLK_DIV   = 1,
    parameter int   GAP_BITS  = 0,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = DEF_IDLE_BIT,
    parameter int   CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    output logic             dout_bit,
    output logic             bit_strobe,
    output logic             word_done,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    localparam int               IDX_W    = clog2(WIDTH);
    localparam int               GAP_W    = clog2(GAP_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    logic [1:0]       state_q, state_d;
    logic             hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic             tick_first, tick_last;
    logic             accept, reload, word_end, gap_end;

    bit_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk          (clk),
        .rst          (rst),
        .en_i         (state_q != S_IDLE),
        .load_i       (reload),
        .tick_first_o (tick_first),
        .tick_last_o  (tick_last)
    );

    assign in_ready   = !hold_valid_q && !rst;
    assign accept     = in_valid && in_ready;
    assign word_end   = (state_q == S_SHIFT) && tick_last && (idx_q == IDX_LAST);
    assign gap_end    = (state_q == S_GAP) && tick_last && (gap_q == GAP_LAST);
    // Back-to-back reload only skips the gap state when there is no gap to insert.
    assign reload     = hold_valid_q && ((state_q == S_IDLE) || gap_end
                                         || (word_end && (GAP_BITS == 0)));
    assign words_sent = sent_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (hold_valid_q) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (word_end) begin
                    if (GAP_BITS > 0)      state_d = S_GAP;
                    else if (hold_valid_q) state_d = S_SHIFT;
                    else                   state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_end) state_d = hold_valid_q ? S_SHIFT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dout_bit   = IDLE_BIT;
        bit_strobe = 1'b0;
        word_done  = 1'b0;
        busy       = 1'b0;
        case (state_q)
            S_SHIFT: begin
                dout_bit   = (MSB_FIRST != 0) ? shift_q[WIDTH-1] : shift_q[0];
                bit_strobe = tick_first;
                word_done  = word_end;
                busy       = 1'b1;
            end
            S_GAP:   busy = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        sent_d       = sent_q;
        if (accept) begin
            hold_d       = din;
            hold_valid_d = 1'b1;
        end
        if (reload) begin
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
            idx_d        = '0;
        end else if ((state_q == S_SHIFT) && tick_last) begin
            shift_d = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], IDLE_BIT}
                                       : {IDLE_BIT, shift_q[WIDTH-1:1]};
            idx_d   = word_end ? '0 : idx_q + 1'b1;
        end
        if (word_end) sent_d = sent_q + 1'b1;
        if (state_q == S_SHIFT) begin
            gap_d = '0;
        end else if ((state_q == S_GAP) && tick_last) begin
            gap_d = gap_end ? '0 : gap_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            shift_q      <= '0;
            idx_q        <= '0;
            gap_q        <= '0;
            sent_q       <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            sent_q       <= sent_d;
        end
    end

    // Accept requires an empty holding register, so it can never meet a reload.
    always @(posedge clk) begin
        if (!rst) assert (!(accept && reload));
    end

endmodule
